// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline register.
// Optional macro FETCH_PERF_CNT_EN adds fetch/bubble performance counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        stall_i,
  input  logic        id_redirect_i,
  input  logic [31:0] id_target_i,
  input  logic        ex_redirect_i,
  input  logic [31:0] ex_target_i,
  input  logic        exc_req_i,
  input  logic        irq_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_plus4_o,
  output logic        ifid_valid_o,
  output logic        irq_taken_o,
  output logic [31:0] irq_ret_pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        irq_taken_q, irq_taken_d;
  logic [31:0] irq_ret_pc_q, irq_ret_pc_d;
  logic [31:0] pc_plus4;
  logic        irq_fire;
  logic        flush;

  assign pc_plus4 = pc_q + 32'd4;
  // Kernel mode (PC[31]) masks interrupts, so handlers never nest.
  assign irq_fire = irq_i && !pc_q[31] && !stall_i;

  always_comb begin
    pc_d            = pc_plus4;
    ifid_instr_d    = rom_data_i;
    ifid_pc_plus4_d = pc_plus4;
    ifid_valid_d    = 1'b1;
    irq_taken_d     = 1'b0;
    irq_ret_pc_d    = irq_ret_pc_q;
    flush           = 1'b0;
    if (exc_req_i) begin
      pc_d  = EXC_VEC;
      flush = 1'b1;
    end else if (ex_redirect_i) begin
      pc_d  = {ex_target_i[31:2], 2'b00};
      flush = 1'b1;
    end else if (id_redirect_i) begin
      pc_d  = {id_target_i[31:2], 2'b00};
      flush = 1'b1;
    end else if (irq_fire) begin
      pc_d         = IRQ_VEC;
      flush        = 1'b1;
      irq_taken_d  = 1'b1;
      irq_ret_pc_d = pc_q;
    end else if (stall_i) begin
      pc_d            = pc_q;
      ifid_instr_d    = ifid_instr_q;
      ifid_pc_plus4_d = ifid_pc_plus4_q;
      ifid_valid_d    = ifid_valid_q;
    end
    if (flush) begin
      ifid_instr_d    = NOP_WORD;
      ifid_pc_plus4_d = pc_plus4;
      ifid_valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q            <= RESET_PC;
      ifid_instr_q    <= NOP_WORD;
      ifid_pc_plus4_q <= 32'd0;
      ifid_valid_q    <= 1'b0;
      irq_taken_q     <= 1'b0;
      irq_ret_pc_q    <= 32'd0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      irq_taken_q     <= irq_taken_d;
      irq_ret_pc_q    <= irq_ret_pc_d;
    end
  end

  assign rom_addr_o      = pc_q;
  assign ifid_instr_o    = ifid_instr_q;
  assign ifid_pc_plus4_o = ifid_pc_plus4_q;
  assign ifid_valid_o    = ifid_valid_q;
  assign irq_taken_o     = irq_taken_q;
  assign irq_ret_pc_o    = irq_ret_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;
  logic        fetch;

  // Every cycle is either a sequential fetch or a bubble (flush or stall).
  assign fetch = !(flush || stall_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else if (fetch) begin
      fetch_cnt_q  <= fetch_cnt_q + 32'd1;
    end else begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Table-driven bench for if_fetch_stage with a queue of expected IF/ID states.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        stall;
  logic        id_redirect;
  logic [31:0] id_target;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        exc_req;
  logic        irq;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        irq_taken;
  logic [31:0] irq_ret_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  typedef struct {
    logic        stall;
    logic        idr;
    logic [31:0] idt;
    logic        exr;
    logic [31:0] ext;
    logic        exc;
    logic        irq;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_taken;
    logic [31:0] e_ret;
  } vec_t;

  vec_t vecs[22];
  vec_t sb_q[$];
  int   n_cmp;
  int   n_fail;

  if_fetch_stage dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .rom_addr_o     (rom_addr),
    .rom_data_i     (rom_data),
    .stall_i        (stall),
    .id_redirect_i  (id_redirect),
    .id_target_i    (id_target),
    .ex_redirect_i  (ex_redirect),
    .ex_target_i    (ex_target),
    .exc_req_i      (exc_req),
    .irq_i          (irq),
    .ifid_instr_o   (ifid_instr),
    .ifid_pc_plus4_o(ifid_pc_plus4),
    .ifid_valid_o   (ifid_valid),
    .irq_taken_o    (irq_taken),
    .irq_ret_pc_o   (irq_ret_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o    (fetch_cnt),
    .bubble_cnt_o   (bubble_cnt)
`endif
  );

  // Bench-owned ROM: every word is distinct from its address and from NOP.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  assign rom_data = rom_word(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic idr, input logic [31:0] idt,
                              input logic exr, input logic [31:0] ext, input logic exc,
                              input logic ir, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] pc4, input logic v, input logic tk,
                              input logic [31:0] ret);
    vec_t r;
    r.stall = s; r.idr = idr; r.idt = idt; r.exr = exr; r.ext = ext; r.exc = exc;
    r.irq = ir; r.e_pc = pc; r.e_instr = ins; r.e_pc4 = pc4; r.e_valid = v;
    r.e_taken = tk; r.e_ret = ret;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    stall = 0; id_redirect = 0; id_target = 0; ex_redirect = 0; ex_target = 0;
    exc_req = 0; irq = 0;
  endtask

  task automatic compare_state(input string tag, input vec_t e);
    check({tag, " pc"}, rom_addr, e.e_pc);
    check({tag, " instr"}, ifid_instr, e.e_instr);
    check({tag, " pc4"}, ifid_pc_plus4, e.e_pc4);
    check({tag, " valid"}, {31'd0, ifid_valid}, {31'd0, e.e_valid});
    check({tag, " irq_taken"}, {31'd0, irq_taken}, {31'd0, e.e_taken});
    check({tag, " ret_pc"}, irq_ret_pc, e.e_ret);
  endtask

  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    @(negedge clk);
    stall = v.stall; id_redirect = v.idr; id_target = v.idt; ex_redirect = v.exr;
    ex_target = v.ext; exc_req = v.exc; irq = v.irq;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: scoreboard empty got 0 expected 1", tag);
    end else begin
      e = sb_q.pop_front();
      compare_state(tag, e);
    end
  endtask

  initial begin
    vec_t rv;
    n_cmp = 0;
    n_fail = 0;
    //          st idr idt           exr ext           exc irq pc            instr                      pc4           v  tk ret
    vecs[0]  = mk(0, 0, 0,            0, 0,            0, 0, 32'h8000_0004, rom_word(32'h8000_0000), 32'h8000_0004, 1, 0, 0);
    vecs[1]  = mk(0, 0, 0,            0, 0,            0, 0, 32'h8000_0008, rom_word(32'h8000_0004), 32'h8000_0008, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0,            0, 0,            0, 0, 32'h8000_000C, rom_word(32'h8000_0008), 32'h8000_000C, 1, 0, 0);
    vecs[3]  = mk(0, 1, 32'h0000_0103, 0, 0,           0, 0, 32'h0000_0100, 32'h0,                   32'h8000_0010, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0,            0, 0,            0, 0, 32'h0000_0104, rom_word(32'h0000_0100), 32'h0000_0104, 1, 0, 0);
    vecs[5]  = mk(1, 0, 0,            0, 0,            0, 0, 32'h0000_0104, rom_word(32'h0000_0100), 32'h0000_0104, 1, 0, 0);
    vecs[6]  = mk(1, 0, 0,            0, 0,            0, 1, 32'h0000_0104, rom_word(32'h0000_0100), 32'h0000_0104, 1, 0, 0);
    vecs[7]  = mk(1, 0, 0,            0, 0,            0, 0, 32'h0000_0104, rom_word(32'h0000_0100), 32'h0000_0104, 1, 0, 0);
    vecs[8]  = mk(0, 0, 0,            0, 0,            0, 0, 32'h0000_0108, rom_word(32'h0000_0104), 32'h0000_0108, 1, 0, 0);
    vecs[9]  = mk(0, 1, 32'h0000_00B4, 1, 32'h0000_0078, 0, 1, 32'h0000_0078, 32'h0,               32'h0000_010C, 0, 0, 0);
    vecs[10] = mk(0, 0, 0,            0, 0,            0, 0, 32'h0000_007C, rom_word(32'h0000_0078), 32'h0000_007C, 1, 0, 0);
    vecs[11] = mk(0, 1, 32'h0000_0050, 0, 0,           0, 0, 32'h0000_0050, 32'h0,                   32'h0000_0080, 0, 0, 0);
    vecs[12] = mk(0, 0, 0,            0, 0,            0, 1, 32'h8000_0004, 32'h0,                   32'h0000_0054, 0, 1, 32'h50);
    vecs[13] = mk(0, 0, 0,            0, 0,            0, 1, 32'h8000_0008, rom_word(32'h8000_0004), 32'h8000_0008, 1, 0, 32'h50);
    vecs[14] = mk(0, 0, 0,            0, 0,            0, 1, 32'h8000_000C, rom_word(32'h8000_0008), 32'h8000_000C, 1, 0, 32'h50);
    vecs[15] = mk(0, 1, 32'h0000_0020, 0, 0,           0, 0, 32'h0000_0020, 32'h0,                   32'h8000_0010, 0, 0, 32'h50);
    vecs[16] = mk(1, 0, 0,            0, 0,            1, 1, 32'h8000_0008, 32'h0,                   32'h0000_0024, 0, 0, 32'h50);
    vecs[17] = mk(0, 0, 0,            0, 0,            0, 0, 32'h8000_000C, rom_word(32'h8000_0008), 32'h8000_000C, 1, 0, 32'h50);
    vecs[18] = mk(0, 1, 32'hFFFF_FFFE, 0, 0,           0, 0, 32'hFFFF_FFFC, 32'h0,                   32'h8000_0010, 0, 0, 32'h50);
    vecs[19] = mk(0, 0, 0,            0, 0,            0, 0, 32'h0000_0000, rom_word(32'hFFFF_FFFC), 32'h0000_0000, 1, 0, 32'h50);
    vecs[20] = mk(1, 0, 0,            1, 32'h0000_0202, 0, 0, 32'h0000_0200, 32'h0,                  32'h0000_0004, 0, 0, 32'h50);
    vecs[21] = mk(1, 0, 0,            0, 0,            0, 0, 32'h0000_0200, 32'h0,                   32'h0000_0004, 0, 0, 32'h50);

    drive_idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    rv = mk(0, 0, 0, 0, 0, 0, 0, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0);
    compare_state("reset", rv);

    for (int i = 0; i < 22; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Async reset while stalled at 0x200: outputs must clear before any clock edge.
    @(negedge clk);
    stall = 1'b1;
    #2 reset = 1'b1;
    #1;
    compare_state("async_reset", rv);
    @(posedge clk);
    #2 reset = 1'b0;
    drive_idle();
    apply("post_reset", mk(0, 0, 0, 0, 0, 0, 0, 32'h8000_0004, rom_word(32'h8000_0000),
                           32'h8000_0004, 1, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS-subset CPU.
- Owns the program counter, drives the combinational instruction ROM address, and captures the returned word into the IF/ID pipeline register.
- Resolves next-PC selection from four sources: sequential, jump/jr (ID), branch (EX) and interrupt/exception vectors.
- Handles pipeline stall and flush.

Parameters:
- RESET_PC, 32'h8000_0000, PC after reset; bit 31 = kernel-mode flag.
- IRQ_VEC, 32'h8000_0004, interrupt vector (ROM word 1).
- EXC_VEC, 32'h8000_0008, exception vector (ROM word 2).
- NOP_WORD, 32'h0000_0000, word injected into IF/ID on flush.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rom_addr  out  32  current PC to ROM (combinational copy of PC register).
- rom_data  in  32  instruction word from ROM, valid same cycle.
- stall  in  1  hazard unit: hold PC and IF/ID.
- id_redirect  in  1  jump/jal/jr resolved in ID.
- id_target  in  32  target for id_redirect.
- ex_redirect  in  1  taken branch resolved in EX.
- ex_target  in  32  target for ex_redirect.
- exc_req  in  1  exception (undefined opcode) from ID.
- irq  in  1  timer interrupt request (level).
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc_plus4  out  32  IF/ID PC+4.
- ifid_valid  out  1  1 = IF/ID holds a real fetched instruction.
- irq_taken  out  1  one-cycle pulse when the interrupt vector is loaded.
- irq_ret_pc  out  32  address of the suppressed instruction; written to $26 downstream.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - PC = RESET_PC; ifid_instr = NOP_WORD; ifid_pc_plus4 = 0; ifid_valid = 0; irq_taken = 0; irq_ret_pc = 0.
  - First fetch happens in the first cycle after reset deasserts.
- pc_plus4 = PC + 4, modulo 2^32; carry into bit 31 discarded, no saturation.
- Next-PC priority, highest first:
  1. exc_req: PC = EXC_VEC; flush IF/ID. Overrides stall.
  2. ex_redirect: PC = ex_target; flush IF/ID. Overrides stall and id_redirect, since the branch is older.
  3. id_redirect: PC = id_target; flush IF/ID. Overrides stall.
  4. Interrupt: taken when irq=1, PC[31]=0 and stall=0.
     - PC = IRQ_VEC; IF/ID flushed.
     - irq_ret_pc = current PC (the instruction not issued).
     - irq_taken = 1 for exactly one cycle.
     - No interrupt while PC[31]=1: kernel mode, no nesting.
  5. stall: PC, ifid_instr, ifid_pc_plus4 and ifid_valid all hold.
  6. Otherwise: PC = pc_plus4; IF/ID = {rom_data, pc_plus4}; ifid_valid = 1.
- Flush: ifid_instr = NOP_WORD; ifid_valid = 0; ifid_pc_plus4 = pc_plus4.
- Targets: bits [1:0] forced to 0 when loaded into PC; all other bits used verbatim, bit 31 included.
- irq_taken is 0 in every cycle the interrupt rule does not fire. irq_ret_pc holds its value until the next interrupt.
- Latency: rom_addr changes the cycle after a redirect; the target instruction appears in IF/ID one cycle later.
- Same-cycle events:
  - id_redirect + ex_redirect → EX wins; the ID jump is discarded because it is on the wrong path.
  - irq + any redirect → redirect wins; irq is re-evaluated next cycle (level-sensitive).

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs fetch_cnt[31:0] (increments on each rule-6 fetch) and bubble_cnt[31:0] (increments on each flush or stall cycle).
  - Both counters reset to 0 and wrap at 2^32.
- Macro undefined: ports and counters are absent; all other behaviour identical.

Test Plan:
- Release reset, no stalls, 4 cycles → rom_addr 8000_0000, _0004, _0008, _000C; ifid_pc_plus4 = 8000_0004 on 2nd edge; ifid_valid=1.
- At PC 0000_0100, stall=1 for 3 cycles → PC and IF/ID frozen; after release, fetch continues at 0000_0104 with no lost or duplicated instruction.
- id_redirect=1, id_target=0000_00B4 and ex_redirect=1, ex_target=0000_0078 in the same cycle → PC=0000_0078; ifid_instr=0; ifid_valid=0.
- PC=0000_0050, irq=1, stall=0 → PC=8000_0004; irq_taken pulses 1 cycle; irq_ret_pc=0000_0050; with irq held while PC=8000_00xx, no second pulse.
- exc_req=1 while stall=1 and irq=1 at PC 0000_0020 → PC=8000_0008; IF/ID flushed; irq_taken=0.
- Assert reset mid-stall at PC 0000_0200 → outputs return to reset values immediately (async); fetch resumes at 8000_0000.
